// File: rtl/pipelined_shift_unit.sv
// Pipelined SLL/SRL/SRA shift unit with RV64 word forms. The log-shifter levels are
// spread evenly over PIPE_STAGES register stages, and the stages use a valid/ready handshake.

module pipelined_shift_unit_stage #(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = 6,
  parameter int TAG_W   = 5,
  parameter int CW      = SHAMT_W + 3,
  parameter int LO      = 0,
  parameter int NLVL    = 3,
  parameter bit LAST    = 1'b0
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             d_vld,
  input  logic [XLEN-1:0]  d_data,
  input  logic [CW-1:0]    d_ctl,
  input  logic [TAG_W-1:0] d_tag,
  output logic             q_vld,
  output logic [XLEN-1:0]  q_data,
  output logic [CW-1:0]    q_ctl,
  output logic [TAG_W-1:0] q_tag
);
  logic [SHAMT_W-1:0] shamt;
  logic               fill, sll, word;
  logic [XLEN-1:0]    sh, res;

  assign {word, sll, fill, shamt} = d_ctl;

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
    return r;
  endfunction

  // This stage applies levels LO..LO+NLVL-1. The last stage also undoes the SLL
  // bit reversal and sign-extends word-form results.
  always_comb begin
    sh = d_data;
    for (int j = 0; j < NLVL; j++)
      if (shamt[LO+j])
        sh = (sh >> (1 << (LO+j))) | (fill ? ~({XLEN{1'b1}} >> (1 << (LO+j))) : '0);
    res = sh;
    if (LAST) begin
      if (sll) res = bit_rev(res);
      if (word)
        for (int i = 32; i < XLEN; i++) res[i] = res[31];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld  <= 1'b0;
      q_data <= '0;
      q_ctl  <= '0;
      q_tag  <= '0;
    end else if (flush) begin
      q_vld <= 1'b0;
    end else if (load) begin
      q_vld <= d_vld;
      if (d_vld) begin
        q_data <= res;
        q_ctl  <= d_ctl;
        q_tag  <= d_tag;
      end
    end
  end
endmodule

module pipelined_shift_unit #(
  parameter int XLEN        = 64,
  parameter int SHAMT_W     = 6,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic               in_word,
  input  logic [XLEN-1:0]    in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_data,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int LPS = SHAMT_W / PIPE_STAGES;
  localparam int CW  = SHAMT_W + 3;

  if (PIPE_STAGES < 1 || PIPE_STAGES > SHAMT_W || (SHAMT_W % PIPE_STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_shift_unit: PIPE_STAGES must be in 1..SHAMT_W and divide SHAMT_W");
  end

  logic [PIPE_STAGES:0]              vld_pipe;
  logic [PIPE_STAGES-1:0]            vld_q;
  logic [PIPE_STAGES:0]              free;
  logic [PIPE_STAGES:0][XLEN-1:0]    p_data;
  logic [PIPE_STAGES:0][CW-1:0]      p_ctl;
  logic [PIPE_STAGES:0][TAG_W-1:0]   p_tag;
  logic                              unused_last_ctl;

  logic               sra, sll, fill;
  logic [SHAMT_W-1:0] shamt_eff;
  logic [XLEN-1:0]    pre;

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
    return r;
  endfunction

  // SLL reuses the right shifter by working on the bit-reversed operand.
  always_comb begin
    sra       = (in_op == 2'b10);
    sll       = (in_op == 2'b00);
    shamt_eff = in_word ? (in_shamt & SHAMT_W'(31)) : in_shamt;
    pre       = in_data;
    if (in_word)
      for (int i = 32; i < XLEN; i++) pre[i] = sra & in_data[31];
    fill = sra & (in_word ? in_data[31] : in_data[XLEN-1]);
    if (sll) pre = bit_rev(pre);
  end

  // Stage k may load if it is empty, or if any later stage has a hole, or if the consumer is draining.
  always_comb begin
    logic acc;
    acc               = out_ready;
    free              = '0;
    free[PIPE_STAGES] = out_ready;
    for (int k = PIPE_STAGES-1; k >= 0; k--) begin
      acc     = acc | ~vld_q[k];
      free[k] = acc;
    end
  end

  assign in_ready    = ~flush & free[0];
  assign vld_pipe    = {vld_q, in_valid & in_ready};
  assign p_data[0]   = pre;
  assign p_ctl[0]    = {in_word, sll, fill, shamt_eff};
  assign p_tag[0]    = in_tag;

  for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
    pipelined_shift_unit_stage #(
      .XLEN(XLEN), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W), .CW(CW),
      .LO(g*LPS), .NLVL(LPS), .LAST(g == PIPE_STAGES-1)
    ) u_stage (
      .clk(clk), .rst_n(rst_n), .flush(flush), .load(free[g]),
      .d_vld(vld_pipe[g]), .d_data(p_data[g]), .d_ctl(p_ctl[g]), .d_tag(p_tag[g]),
      .q_vld(vld_q[g]), .q_data(p_data[g+1]), .q_ctl(p_ctl[g+1]), .q_tag(p_tag[g+1])
    );
  end

  assign unused_last_ctl = ^p_ctl[PIPE_STAGES];
  assign out_valid       = vld_pipe[PIPE_STAGES];
  assign out_data        = p_data[PIPE_STAGES];
  assign out_tag         = p_tag[PIPE_STAGES];
endmodule
